// File: rtl/hdmi_frame_checker.sv
// rtl/hdmi_frame_checker.sv - self-checking sink for decoded HDMI video with per-frame statistics
module hdmi_frame_checker #(
    parameter int          XBITS     = 12,
    parameter int          YBITS     = 12,
    parameter int          ERR_BITS  = 16,
    parameter logic        VS_ACTIVE = 1'b1,
    parameter logic [23:0] SOLID     = 24'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                de_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic [23:0]         rgb_in,
    input  logic [1:0]          mode_in,
    output logic                frame_done,
    output logic [7:0]          frame_count,
    output logic [ERR_BITS-1:0] err_count,
    output logic [XBITS-1:0]    first_err_x,
    output logic [YBITS-1:0]    first_err_y,
    output logic [XBITS-1:0]    meas_width,
    output logic [YBITS-1:0]    meas_height,
    output logic                line_len_err,
    output logic                locked
);

    typedef enum logic {WAIT_SYNC, RUN} state_t;

    state_t              state, state_next;
    logic                vs_q, de_q;
    logic [1:0]          mode_q;
    logic [XBITS-1:0]    x_cnt, ref_w, fe_x;
    logic [YBITS-1:0]    y_cnt, fe_y;
    logic [ERR_BITS-1:0] err_run;
    logic                err_seen, have_ref, len_err_run;

    logic                frame_edge, report, line_end, mismatch;
    logic [XBITS-1:0]    cur_x;
    logic [YBITS-1:0]    cur_y;
    logic [1:0]          cur_mode;
    logic [23:0]         expected;

    // hsync is monitored only; it deliberately drives nothing
    logic unused_hsync;
    assign unused_hsync = hsync_in;

    assign frame_edge = (vsync_in == VS_ACTIVE) && (vs_q != VS_ACTIVE);
    // A de fall coinciding with a frame edge is absorbed by the edge clear
    assign line_end   = de_q && !de_in && !frame_edge;

    // A pixel on the frame-edge cycle belongs to the new frame: (0,0) and the newly latched mode
    always_comb begin
        cur_x    = frame_edge ? '0 : x_cnt;
        cur_y    = frame_edge ? '0 : y_cnt;
        cur_mode = frame_edge ? mode_in : mode_q;
        expected = 24'h0;
        case (cur_mode)
            2'd0:    expected = 24'(cur_x) ^ 24'(cur_y);
            2'd1:    expected = {cur_x[7:0], cur_x[7:0], cur_x[7:0]};
            2'd2:    expected = SOLID;
            default: expected = 24'h0;
        endcase
        mismatch = de_in && (cur_mode != 2'd3) && (rgb_in != expected);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_SYNC;
        else     state <= state_next;
    end

    // Next state; only frame edges seen while running produce a report
    always_comb begin
        state_next = state;
        report     = 1'b0;
        case (state)
            WAIT_SYNC: if (frame_edge) state_next = RUN;
            RUN:       report = frame_edge;
            default:   state_next = WAIT_SYNC;
        endcase
    end

    // Running pixel position, error and line-length tracking for the frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            mode_q      <= 2'd0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            err_run     <= '0;
            err_seen    <= 1'b0;
            fe_x        <= '0;
            fe_y        <= '0;
            ref_w       <= '0;
            have_ref    <= 1'b0;
            len_err_run <= 1'b0;
        end else begin
            vs_q <= vsync_in;
            de_q <= de_in;
            if (frame_edge) begin
                mode_q      <= mode_in;
                x_cnt       <= de_in ? XBITS'(1) : '0;
                y_cnt       <= '0;
                err_run     <= mismatch ? ERR_BITS'(1) : '0;
                err_seen    <= mismatch;
                fe_x        <= '0;
                fe_y        <= '0;
                ref_w       <= '0;
                have_ref    <= 1'b0;
                len_err_run <= 1'b0;
            end else begin
                if (de_in) x_cnt <= x_cnt + XBITS'(1);
                if (mismatch) begin
                    if (err_run != '1) err_run <= err_run + ERR_BITS'(1);
                    if (!err_seen) begin
                        err_seen <= 1'b1;
                        fe_x     <= cur_x;
                        fe_y     <= cur_y;
                    end
                end
                if (line_end) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + YBITS'(1);
                    if (!have_ref) begin
                        ref_w    <= x_cnt;
                        have_ref <= 1'b1;
                    end else if (x_cnt != ref_w) begin
                        len_err_run <= 1'b1;
                    end
                end
            end
        end
    end

    // Publish the finished frame's results one cycle after its closing frame edge
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done   <= 1'b0;
            frame_count  <= 8'd0;
            err_count    <= '0;
            first_err_x  <= '0;
            first_err_y  <= '0;
            meas_width   <= '0;
            meas_height  <= '0;
            line_len_err <= 1'b0;
            locked       <= 1'b0;
        end else begin
            frame_done <= report;
            if (report) begin
                frame_count  <= frame_count + 8'd1;
                err_count    <= err_run;
                first_err_x  <= fe_x;
                first_err_y  <= fe_y;
                meas_width   <= ref_w;
                meas_height  <= y_cnt;
                line_len_err <= len_err_run;
                locked       <= (ref_w == meas_width) && (y_cnt == meas_height) &&
                                (ref_w != '0) && (y_cnt != '0) && !len_err_run;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_frame_checker.sv
// tb/tb_hdmi_frame_checker.sv - directed self-checking bench for hdmi_frame_checker
module tb_hdmi_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_in, hsync_in, vsync_in;
    logic [23:0] rgb_in;
    logic [1:0]  mode_in;

    logic        frame_done, line_len_err, locked;
    logic [7:0]  frame_count;
    logic [15:0] err_count;
    logic [11:0] first_err_x, meas_width;
    logic [11:0] first_err_y, meas_height;

    logic        e2_frame_done, e2_line_len_err, e2_locked;
    logic [7:0]  e2_frame_count;
    logic [3:0]  e2_err_count;
    logic [11:0] e2_first_err_x, e2_meas_width;
    logic [11:0] e2_first_err_y, e2_meas_height;

    int tests_run    = 0;
    int tests_failed = 0;
    logic done_at_edge;

    always #5 clk = ~clk;

    hdmi_frame_checker dut (
        .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .mode_in(mode_in), .frame_done(frame_done), .frame_count(frame_count),
        .err_count(err_count), .first_err_x(first_err_x), .first_err_y(first_err_y),
        .meas_width(meas_width), .meas_height(meas_height), .line_len_err(line_len_err),
        .locked(locked)
    );

    hdmi_frame_checker #(.ERR_BITS(4), .SOLID(24'h123456)) dut_sat (
        .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .mode_in(mode_in), .frame_done(e2_frame_done),
        .frame_count(e2_frame_count), .err_count(e2_err_count),
        .first_err_x(e2_first_err_x), .first_err_y(e2_first_err_y),
        .meas_width(e2_meas_width), .meas_height(e2_meas_height),
        .line_len_err(e2_line_len_err), .locked(e2_locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vsync pulse; mode_in is presented on the edge cycle where it is latched
    task automatic vs_edge(input logic [1:0] mode);
        mode_in  = mode;
        vsync_in = 1'b1;
        tick();
        done_at_edge = frame_done;
        tick();
        vsync_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_lines(input int w, input int h, input int bad_x, input int bad_y,
                              input int short_y, input logic zero_rgb);
        for (int y = 0; y < h; y++) begin
            int len;
            len = (y == short_y) ? w - 1 : w;
            for (int x = 0; x < len; x++) begin
                de_in = 1'b1;
                if (zero_rgb)                      rgb_in = 24'h0;
                else if (x == bad_x && y == bad_y) rgb_in = 24'hFFFFFF;
                else                               rgb_in = 24'(x ^ y);
                tick();
            end
            de_in    = 1'b0;
            rgb_in   = 24'h0;
            hsync_in = 1'b1;
            tick();
            hsync_in = 1'b0;
            tick();
            tick();
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        rgb_in = 24'h0; mode_in = 2'd0;
        tick();
        tick();
        check("rst_done", frame_done, 0);
        check("rst_count", frame_count, 0);
        check("rst_width", meas_width, 0);
        check("rst_locked", locked, 0);
        rst = 1'b0;
        tick();

        // 1: 4x4 mode 0, three frames
        vs_edge(2'd0);
        check("t1_first_edge_no_done", done_at_edge, 0);
        send_lines(4, 4, -1, -1, -1, 1'b0);
        vs_edge(2'd0);
        check("t1_done_f1", done_at_edge, 1);
        check("t1_done_drops", frame_done, 0);
        check("t1_count1", frame_count, 1);
        check("t1_err", err_count, 0);
        check("t1_w", meas_width, 4);
        check("t1_h", meas_height, 4);
        check("t1_unlocked", locked, 0);
        send_lines(4, 4, -1, -1, -1, 1'b0);
        vs_edge(2'd0);
        check("t1_done_f2", done_at_edge, 1);
        check("t1_count2", frame_count, 2);
        check("t1_locked", locked, 1);

        // 2: one corrupted pixel at (2,1)
        send_lines(4, 4, 2, 1, -1, 1'b0);
        vs_edge(2'd0);
        check("t2_err", err_count, 1);
        check("t2_fx", first_err_x, 2);
        check("t2_fy", first_err_y, 1);
        check("t2_locked", locked, 1);
        check("t2_count", frame_count, 3);

        // 3: resolution change to 8x4
        send_lines(8, 4, -1, -1, -1, 1'b0);
        vs_edge(2'd0);
        check("t3_w", meas_width, 8);
        check("t3_h", meas_height, 4);
        check("t3_unlocked", locked, 0);
        check("t3_fx_clear", first_err_x, 0);
        send_lines(8, 4, -1, -1, -1, 1'b0);
        vs_edge(2'd2);
        check("t3_relock", locked, 1);

        // 4: mode 2 with rgb=0 on 4x8; the ERR_BITS=4 instance saturates
        send_lines(4, 8, -1, -1, -1, 1'b1);
        vs_edge(2'd0);
        check("t4_sat_err", e2_err_count, 4'hF);
        check("t4_sat_fx", e2_first_err_x, 0);
        check("t4_sat_fy", e2_first_err_y, 0);
        check("t4_solid0_err", err_count, 0);
        check("t4_w", meas_width, 4);
        check("t4_h", meas_height, 8);

        // 5: short line 2, then the same stream in capture-only mode with a bad pixel
        send_lines(4, 4, -1, -1, 2, 1'b0);
        vs_edge(2'd3);
        check("t5_len_err", line_len_err, 1);
        check("t5_unlocked", locked, 0);
        check("t5_err", err_count, 0);
        send_lines(4, 4, 1, 1, 2, 1'b0);
        vs_edge(2'd3);
        check("t5_m3_err", err_count, 0);
        check("t5_m3_len_err", line_len_err, 1);

        // 6: reset mid-frame
        send_lines(4, 2, -1, -1, -1, 1'b0);
        rst = 1'b1;
        tick();
        check("t6_count0", frame_count, 0);
        check("t6_len0", line_len_err, 0);
        check("t6_w0", meas_width, 0);
        check("t6_h0", meas_height, 0);
        rst = 1'b0;
        send_lines(4, 2, -1, -1, -1, 1'b0);
        vs_edge(2'd0);
        check("t6_first_edge_no_done", done_at_edge, 0);
        send_lines(4, 4, -1, -1, -1, 1'b0);
        vs_edge(2'd0);
        check("t6_done", done_at_edge, 1);
        check("t6_count1", frame_count, 1);
        check("t6_h", meas_height, 4);
        check("t6_unlocked", locked, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
